bench_resp_misr: RTL and testbench

//   Downstream response compactor for the 7-bit output of the generic combinational

---
 rtl/bench_resp_pkg.sv | 36 +++
 rtl/misr_core.sv | 41 ++++
 rtl/bench_resp_misr.sv | 121 ++++++++++++
 tb/tb_bench_resp_misr.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bench_resp_pkg.sv
// Shared types and helpers for the benchmark response compactor.
//   state_t     : controller states (IDLE, RUN, DONE)
//   MISR_W_DEF  : default signature width
//   POLY_DEF    : default Galois feedback polynomial (x^16+x^12+x^5+1)
//   MISR_MAX    : widest signature the helper function supports
//   misr_next() : one MISR step for any width up to MISR_MAX
package bench_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int               MISR_W_DEF = 16;
  localparam logic [15:0]      POLY_DEF   = 16'h1021;
  localparam int               MISR_MAX   = 64;

  // One Galois MISR step on a 'width'-bit register held in the low bits of
  // MISR_MAX-wide operands. 'resp' must already be zero-extended. Bits at and
  // above 'width' are cleared so the caller can truncate freely.
  function automatic logic [MISR_MAX-1:0] misr_next(
    input logic [MISR_MAX-1:0] sig,
    input logic [MISR_MAX-1:0] resp,
    input logic [MISR_MAX-1:0] poly,
    input int                  width
  );
    logic [MISR_MAX-1:0] mask;
    logic                fb;
    // For width == MISR_MAX the shift yields 0 and the subtract wraps to all ones.
    mask = (MISR_MAX'(1) << width) - MISR_MAX'(1);
    fb   = |(sig & (MISR_MAX'(1) << (width - 1)));
    return ((sig << 1) ^ (fb ? poly : '0) ^ resp) & mask;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register.
//   clk  in  1       rising-edge clock
//   rst  in  1       synchronous active-high reset, loads seed
//   load in  1       load seed (wins over en)
//   en   in  1       fold din into the signature
//   seed in  MISR_W  value loaded on reset / load
//   din  in  MISR_W  zero-extended response vector
//   sig  out MISR_W  current signature (registered)
module misr_core
  import bench_resp_pkg::*;
#(
  parameter int                MISR_W = MISR_W_DEF,
  parameter logic [MISR_W-1:0] POLY   = MISR_W'(POLY_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [MISR_W-1:0] seed,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= seed;
    end else if (load) begin
      sig_q <= seed;
    end else if (en) begin
      sig_q <= MISR_W'(misr_next(MISR_MAX'(sig_q), MISR_MAX'(din),
                                 MISR_MAX'(POLY), MISR_W));
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bench_resp_misr.sv
// Response compactor placed after a combinational benchmark under test.
// Folds one response vector per handshake into a MISR; after N_VECTORS
// accepted vectors it stops in DONE and compares the signature with GOLDEN.
// RESP_W must not exceed MISR_W; N_VECTORS must be at least 1.
//   clk        in  1        rising-edge clock
//   rst        in  1        synchronous active-high reset
//   start      in  1        begin a run (ignored while RUN)
//   abort      in  1        discard the run, return to IDLE
//   resp       in  RESP_W   benchmark response vector
//   resp_valid in  1        resp is valid this cycle
//   resp_ready out 1        vector accepted this cycle when valid (RUN only)
//   vec_count  out CNT_W    vectors accepted in the current run
//   signature  out MISR_W   current MISR contents
//   busy       out 1        in RUN
//   done       out 1        in DONE
//   pass       out 1        done and signature == GOLDEN
module bench_resp_misr
  import bench_resp_pkg::*;
#(
  parameter int                RESP_W    = 7,
  parameter int                MISR_W    = MISR_W_DEF,
  parameter logic [MISR_W-1:0] POLY      = MISR_W'(POLY_DEF),
  parameter logic [MISR_W-1:0] SEED      = '0,
  parameter int                N_VECTORS = 64,
  parameter logic [MISR_W-1:0] GOLDEN    = '0,
  localparam int               CNT_W     = $clog2(N_VECTORS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RESP_W-1:0] resp,
  input  logic              resp_valid,
  output logic              resp_ready,
  output logic [CNT_W-1:0]  vec_count,
  output logic [MISR_W-1:0] signature,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic              accept;
  logic              last_vec;
  logic              load;

  // abort outranks a same-cycle handshake: the vector is neither counted nor folded.
  assign accept   = (state_q == RUN) && resp_valid && !abort;
  assign last_vec = (count_q == CNT_W'(N_VECTORS - 1));
  assign load     = abort || (start && (state_q != RUN));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first keeps this block purely combinational
    // (no latch on paths that leave state_d otherwise untouched).
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (accept && last_vec) state_d = DONE;
        DONE:    if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Accepted-vector counter; stays at N_VECTORS while DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  misr_core #(
    .MISR_W (MISR_W),
    .POLY   (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (accept),
    .seed (SEED),
    .din  (MISR_W'(resp)),
    .sig  (signature)
  );

  // Output decode from registered state only
  always_comb begin
    resp_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    unique case (state_q)
      RUN: begin
        resp_ready = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        pass = (signature == GOLDEN);
      end
      default: ;
    endcase
  end

  assign vec_count = count_q;

endmodule

// File: tb/tb_bench_resp_misr.sv
// Self-checking bench for bench_resp_misr. Three instances share stimulus:
//   dut 0 : N_VECTORS=2,  GOLDEN=0003
//   dut 1 : N_VECTORS=64, GOLDEN=0000
//   dut 2 : N_VECTORS=64, GOLDEN=1234
// A reference model tracks each instance as mode / signature / count, with
// the signature treated as a polynomial over GF(2): multiply by x modulo
// x^16+x^12+x^5+1, then add the response.
module tb_bench_resp_misr;

  logic       clk = 1'b0;
  logic       rst, start, abort, resp_valid;
  logic [6:0] resp;

  always #5 clk = ~clk;

  logic [15:0] o_sig  [3];
  logic [7:0]  o_cnt  [3];
  logic        o_rdy  [3];
  logic        o_busy [3];
  logic        o_done [3];
  logic        o_pass [3];
  logic [1:0]  cnt_a;
  logic [6:0]  cnt_b, cnt_c;

  assign o_cnt[0] = {6'd0, cnt_a};
  assign o_cnt[1] = {1'b0, cnt_b};
  assign o_cnt[2] = {1'b0, cnt_c};

  bench_resp_misr #(.N_VECTORS(2), .SEED(16'h0000), .GOLDEN(16'h0003)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp),
    .resp_valid(resp_valid), .resp_ready(o_rdy[0]), .vec_count(cnt_a),
    .signature(o_sig[0]), .busy(o_busy[0]), .done(o_done[0]), .pass(o_pass[0]));

  bench_resp_misr #(.N_VECTORS(64), .SEED(16'h0000), .GOLDEN(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp),
    .resp_valid(resp_valid), .resp_ready(o_rdy[1]), .vec_count(cnt_b),
    .signature(o_sig[1]), .busy(o_busy[1]), .done(o_done[1]), .pass(o_pass[1]));

  bench_resp_misr #(.N_VECTORS(64), .SEED(16'h0000), .GOLDEN(16'h1234)) dut_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .resp(resp),
    .resp_valid(resp_valid), .resp_ready(o_rdy[2]), .vec_count(cnt_c),
    .signature(o_sig[2]), .busy(o_busy[2]), .done(o_done[2]), .pass(o_pass[2]));

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int          n_vec [3] = '{2, 64, 64};
  logic [15:0] gold  [3] = '{16'h0003, 16'h0000, 16'h1234};
  int          m_mode [3];
  logic [15:0] m_sig  [3];
  int          m_cnt  [3];

  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [15:0] mulx_add(input logic [15:0] s, input logic [6:0] d);
    logic [16:0] p;
    p = {s, 1'b0};
    if (p[16]) p = p ^ 17'h1_1021;
    return p[15:0] ^ {9'd0, d};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst || abort) begin
        m_mode[k] = M_IDLE; m_sig[k] = 16'h0000; m_cnt[k] = 0;
      end else if (start && m_mode[k] != M_RUN) begin
        m_mode[k] = M_RUN; m_sig[k] = 16'h0000; m_cnt[k] = 0;
      end else if (m_mode[k] == M_RUN && resp_valid) begin
        m_sig[k] = mulx_add(m_sig[k], resp);
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == n_vec[k]) m_mode[k] = M_DONE;
      end
    end
  endtask

  // Packed views: {signature, count, ready, busy, done, pass}
  function automatic logic [27:0] obs(input int k);
    return {o_sig[k], o_cnt[k], o_rdy[k], o_busy[k], o_done[k], o_pass[k]};
  endfunction

  function automatic logic [27:0] expv(input int k);
    logic r, d;
    r = (m_mode[k] == M_RUN);
    d = (m_mode[k] == M_DONE);
    return {m_sig[k], 8'(m_cnt[k]), r, r, d, d && (m_sig[k] == gold[k])};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic tick(input logic r, input logic s, input logic a,
                      input logic v, input logic [6:0] d);
    rst = r; start = s; abort = a; resp_valid = v; resp = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(1, 1, 0, 1, 7'h55);
    tick(1, 1, 0, 1, 7'h2a);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (obs(k) !== {16'h0000, 8'd0, 4'b0000}) begin
        n_bad++;
        $display("FAIL reset dut%0d: got %h expected %h", k, obs(k), {16'h0000, 8'd0, 4'b0000});
      end
    end
  endtask

  task automatic test_two_vectors();
    tick(0, 1, 0, 0, 7'h00);
    n_total++;
    if (o_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL start_busy: got %b expected 1", o_busy[0]);
    end
    tick(0, 0, 0, 1, 7'h01);
    n_total++;
    if (o_sig[0] !== 16'h0001) begin
      n_bad++; $display("FAIL two_vec_sig1: got %h expected 0001", o_sig[0]);
    end
    tick(0, 0, 0, 1, 7'h01);
    n_total++;
    if ({o_sig[0], o_done[0], o_pass[0], o_cnt[0]} !== {16'h0003, 1'b1, 1'b1, 8'd2}) begin
      n_bad++;
      $display("FAIL two_vec_final: got sig=%h done=%b pass=%b cnt=%0d expected sig=0003 done=1 pass=1 cnt=2",
               o_sig[0], o_done[0], o_pass[0], o_cnt[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (obs(k) !== expv(k)) begin
        n_bad++; $display("FAIL two_vec_model dut%0d: got %h expected %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_zero_run();
    tick(0, 0, 1, 0, 7'h00);
    tick(0, 1, 0, 0, 7'h00);
    for (int i = 0; i < 64; i++) begin
      tick(0, 0, 0, 1, 7'h00);
      if (i == 62) begin
        n_total++;
        if ({o_done[1], o_busy[1], o_cnt[1]} !== {1'b0, 1'b1, 8'd63}) begin
          n_bad++;
          $display("FAIL zero_run_63: got done=%b busy=%b cnt=%0d expected done=0 busy=1 cnt=63",
                   o_done[1], o_busy[1], o_cnt[1]);
        end
      end
    end
    n_total++;
    if ({o_sig[1], o_done[1], o_pass[1], o_cnt[1]} !== {16'h0000, 1'b1, 1'b1, 8'd64}) begin
      n_bad++;
      $display("FAIL zero_run_golden0: got sig=%h done=%b pass=%b cnt=%0d expected 0000 1 1 64",
               o_sig[1], o_done[1], o_pass[1], o_cnt[1]);
    end
    n_total++;
    if ({o_done[2], o_pass[2]} !== 2'b10) begin
      n_bad++;
      $display("FAIL zero_run_golden1234: got done=%b pass=%b expected done=1 pass=0", o_done[2], o_pass[2]);
    end
    // Held in DONE with resp_valid still high: nothing may change.
    tick(0, 0, 0, 1, 7'h7f);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (obs(k) !== expv(k)) begin
        n_bad++; $display("FAIL zero_run_hold dut%0d: got %h expected %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_random_gaps();
    tick(0, 0, 1, 1, 7'h33);
    for (int c = 0; c < 400; c++) begin
      tick(0, ($urandom_range(15) == 0), ($urandom_range(199) == 0),
           1'($urandom), 7'($urandom));
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (obs(k) !== expv(k)) begin
          n_bad++; $display("FAIL random c%0d dut%0d: got %h expected %h", c, k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_abort_restart();
    // Abort after 10 accepts
    tick(0, 0, 1, 0, 7'h00);
    tick(0, 1, 0, 0, 7'h00);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 7'($urandom));
    tick(0, 0, 1, 1, 7'h11);
    n_total++;
    if ({o_busy[1], o_done[1], o_cnt[1], o_sig[1]} !== {1'b0, 1'b0, 8'd0, 16'h0000}) begin
      n_bad++;
      $display("FAIL abort10: got busy=%b done=%b cnt=%0d sig=%h expected 0 0 0 0000",
               o_busy[1], o_done[1], o_cnt[1], o_sig[1]);
    end
    // Abort coinciding with the final accept of dut 0
    tick(0, 1, 0, 0, 7'h00);
    tick(0, 0, 0, 1, 7'h05);
    tick(0, 0, 1, 1, 7'h06);
    n_total++;
    if ({o_done[0], o_busy[0], o_cnt[0], o_sig[0]} !== {1'b0, 1'b0, 8'd0, 16'h0000}) begin
      n_bad++;
      $display("FAIL abort_final: got done=%b busy=%b cnt=%0d sig=%h expected 0 0 0 0000",
               o_done[0], o_busy[0], o_cnt[0], o_sig[0]);
    end
    // Start from DONE restarts directly into RUN
    tick(0, 1, 0, 0, 7'h00);
    tick(0, 0, 0, 1, 7'h41);
    tick(0, 0, 0, 1, 7'h22);
    tick(0, 1, 0, 1, 7'h7f);
    n_total++;
    if ({o_busy[0], o_done[0], o_cnt[0], o_sig[0]} !== {1'b1, 1'b0, 8'd0, 16'h0000}) begin
      n_bad++;
      $display("FAIL done_restart: got busy=%b done=%b cnt=%0d sig=%h expected 1 0 0 0000",
               o_busy[0], o_done[0], o_cnt[0], o_sig[0]);
    end
    // Reset in the middle of a run
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 7'($urandom));
    tick(1, 0, 0, 1, 7'h12);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (obs(k) !== {16'h0000, 8'd0, 4'b0000}) begin
        n_bad++;
        $display("FAIL rst_mid_run dut%0d: got %h expected %h", k, obs(k), {16'h0000, 8'd0, 4'b0000});
      end
    end
    // Model cross-check after a fresh short run
    tick(0, 1, 0, 0, 7'h00);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 7'($urandom));
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (obs(k) !== expv(k)) begin
        n_bad++; $display("FAIL post_rst_run dut%0d: got %h expected %h", k, obs(k), expv(k));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0; resp = '0;
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = M_IDLE; m_sig[k] = 16'h0000; m_cnt[k] = 0;
    end
    test_reset();
    test_two_vectors();
    test_zero_run();
    test_random_gaps();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
